// File: rtl/ramif_pkg.sv
// Shared definitions for the nibble-serial RAM interface: FSM states and
// chunk/counter sizing helpers used by the burst reader and the tilemap renderer.
package ramif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DATA = 2'd3
    } ramif_state_t;

    // Number of pin-wide chunks needed to move a word of the given width.
    function automatic int unsigned chunk_count(input int unsigned bits,
                                                input int unsigned pins);
        return bits / pins;
    endfunction

    function automatic int unsigned chunk_cnt_width(input int unsigned ac,
                                                    input int unsigned dc,
                                                    input int unsigned lat);
        int unsigned m;
        m = 2;
        if (ac > m)  m = ac;
        if (dc > m)  m = dc;
        if (lat > m) m = lat;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/ramif_chunk_shifter.sv
// Address PISO and data SIPO for the RAM pins; both are indexed by the
// controller's chunk counter, LSB chunk first.
module ramif_chunk_shifter
    import ramif_pkg::*;
#(
    parameter int unsigned RAM_PINS  = 4,
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned CW        = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [CW-1:0]        i_idx,
    input  logic                 i_sample,
    input  logic                 i_word_done,
    input  logic [RAM_PINS-1:0]  i_data_pins,
    output logic [RAM_PINS-1:0]  o_addr_chunk,
    output logic [DATA_BITS-1:0] o_word
);

    localparam int unsigned AC = chunk_count(ADDR_BITS, RAM_PINS);
    localparam int unsigned DC = chunk_count(DATA_BITS, RAM_PINS);

    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_sipo;
    logic [DATA_BITS-1:0] r_word;
    logic [DATA_BITS-1:0] w_word_nxt;

    always_comb begin
        o_addr_chunk = '0;
        for (int k = 0; k < AC; k++) begin
            if (i_idx == CW'(k)) o_addr_chunk = r_addr[k*RAM_PINS +: RAM_PINS];
        end
    end

    // Word as it stands once the current chunk lands; also feeds the output
    // register on the last chunk so no extra cycle is spent assembling.
    always_comb begin
        w_word_nxt = r_sipo;
        for (int k = 0; k < DC; k++) begin
            if (i_idx == CW'(k)) w_word_nxt[k*RAM_PINS +: RAM_PINS] = i_data_pins;
        end
    end

    // NOTE: the data registers are reset too, so a burst cut short by reset
    // can never surface a stale partial word afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_sipo <= '0;
            r_word <= '0;
        end else begin
            if (i_load)      r_addr <= i_addr;
            if (i_sample)    r_sipo <= w_word_nxt;
            if (i_word_done) r_word <= w_word_nxt;
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/ramif_burst_reader.sv
// Nibble-serial RAM burst read controller: sends an address chunk-serially,
// waits LATENCY cycles, then streams back 1..2**BURST_BITS data words.
module ramif_burst_reader
    import ramif_pkg::*;
#(
    parameter int unsigned RAM_PINS   = 4,
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned BURST_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [BURST_BITS-1:0] req_burst,
    output logic [RAM_PINS-1:0]   addr_pins,
    output logic                  addr_start,
    input  logic [RAM_PINS-1:0]   data_pins,
    output logic                  rsp_valid,
    output logic [DATA_BITS-1:0]  rsp_data,
    output logic                  rsp_last,
    output logic                  busy
);

    localparam int unsigned AC = chunk_count(ADDR_BITS, RAM_PINS);
    localparam int unsigned DC = chunk_count(DATA_BITS, RAM_PINS);
    localparam int unsigned CW = chunk_cnt_width(AC, DC, LATENCY);

    localparam logic [CW-1:0] AC_LAST  = CW'(AC - 1);
    localparam logic [CW-1:0] DC_LAST  = CW'(DC - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

    generate
        if (RAM_PINS < 1) begin : g_bad_pins
            $error("ramif_burst_reader: RAM_PINS must be at least 1");
        end
        if (ADDR_BITS % RAM_PINS != 0) begin : g_bad_addr
            $error("ramif_burst_reader: RAM_PINS must divide ADDR_BITS");
        end
        if (DATA_BITS % RAM_PINS != 0) begin : g_bad_data
            $error("ramif_burst_reader: RAM_PINS must divide DATA_BITS");
        end
    endgenerate

    ramif_state_t          r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [BURST_BITS-1:0] r_word, w_word_nxt;
    logic [BURST_BITS-1:0] r_burst;
    logic                  r_rsp_valid;
    logic                  r_rsp_last;

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_burst_done;
    logic [RAM_PINS-1:0]   w_addr_chunk;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_word_done  = (r_state == DATA) && (r_cnt == DC_LAST);
    assign w_burst_done = w_word_done && (r_word == r_burst);

    // NOTE: every combinational output is given a default before the case,
    // so no path through the decode can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_word_nxt = '0;
                if (req_valid) w_state_nxt = ADDR;
            end
            ADDR: begin
                if (r_cnt == AC_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (LATENCY > 0) ? WAIT : DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            WAIT: begin
                if (r_cnt == LAT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DATA: begin
                if (r_cnt == DC_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_word == r_burst) w_state_nxt = IDLE;
                    else                   w_word_nxt  = r_word + BURST_BITS'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            r_burst     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_word      <= w_word_nxt;
            r_rsp_valid <= w_word_done;
            r_rsp_last  <= w_burst_done;
            if (w_accept) r_burst <= req_burst;
        end
    end

    ramif_chunk_shifter #(
        .RAM_PINS  (RAM_PINS),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .CW        (CW)
    ) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_accept),
        .i_addr       (req_addr),
        .i_idx        (r_cnt),
        .i_sample     (r_state == DATA),
        .i_word_done  (w_word_done),
        .i_data_pins  (data_pins),
        .o_addr_chunk (w_addr_chunk),
        .o_word       (rsp_data)
    );

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign addr_start = (r_state == ADDR) && (r_cnt == '0);
    assign addr_pins  = (r_state == ADDR) ? w_addr_chunk : '0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_last   = r_rsp_last;

endmodule

// File: tb/tb_ramif_burst_reader.sv
// Directed bench for ramif_burst_reader: default build plus a 2-pin,
// zero-latency build, with a cycle-stamped response scoreboard for each.
module tb_ramif_burst_reader;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    // DUT A: defaults (4 pins, 16/16 bits, LATENCY 1)
    logic        req_valid_a, req_ready_a, addr_start_a, rsp_valid_a, rsp_last_a, busy_a;
    logic [15:0] req_addr_a, rsp_data_a;
    logic [1:0]  req_burst_a;
    logic [3:0]  addr_pins_a, data_pins_a;

    // DUT B: 2 pins, 8-bit data, LATENCY 0
    logic        req_valid_b, req_ready_b, addr_start_b, rsp_valid_b, rsp_last_b, busy_b;
    logic [15:0] req_addr_b;
    logic [7:0]  rsp_data_b;
    logic [1:0]  req_burst_b;
    logic [1:0]  addr_pins_b, data_pins_b;

    always #5 clk = ~clk;

    ramif_burst_reader u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_a),
        .req_ready  (req_ready_a),
        .req_addr   (req_addr_a),
        .req_burst  (req_burst_a),
        .addr_pins  (addr_pins_a),
        .addr_start (addr_start_a),
        .data_pins  (data_pins_a),
        .rsp_valid  (rsp_valid_a),
        .rsp_data   (rsp_data_a),
        .rsp_last   (rsp_last_a),
        .busy       (busy_a)
    );

    ramif_burst_reader #(
        .RAM_PINS   (2),
        .ADDR_BITS  (16),
        .DATA_BITS  (8),
        .LATENCY    (0),
        .BURST_BITS (2)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_addr   (req_addr_b),
        .req_burst  (req_burst_b),
        .addr_pins  (addr_pins_b),
        .addr_start (addr_start_b),
        .data_pins  (data_pins_b),
        .rsp_valid  (rsp_valid_b),
        .rsp_data   (rsp_data_b),
        .rsp_last   (rsp_last_b),
        .busy       (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock, then compare both response ports against their scoreboards.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb_a.size() > 0 && sb_a[0].cyc == cyc) begin
            e = sb_a.pop_front();
            check("a_rsp_valid", rsp_valid_a, 1'b1);
            check("a_rsp_data", rsp_data_a, e.data);
            check("a_rsp_last", rsp_last_a, e.last);
        end else begin
            check("a_rsp_valid_idle", rsp_valid_a, 1'b0);
            check("a_rsp_last_idle", rsp_last_a, 1'b0);
        end
        if (sb_b.size() > 0 && sb_b[0].cyc == cyc) begin
            e = sb_b.pop_front();
            check("b_rsp_valid", rsp_valid_b, 1'b1);
            check("b_rsp_data", rsp_data_b, e.data);
            check("b_rsp_last", rsp_last_b, e.last);
        end else begin
            check("b_rsp_valid_idle", rsp_valid_b, 1'b0);
            check("b_rsp_last_idle", rsp_last_b, 1'b0);
        end
    endtask

    // Called in the acceptance cycle; returns in the cycle of the final response.
    task automatic req_a(input logic [15:0] addr, input logic [1:0] burst,
                         input logic [3:0][15:0] words, input logic hold,
                         input logic [15:0] busy_addr);
        req_valid_a = 1'b1;
        req_addr_a  = addr;
        req_burst_a = burst;
        check("a_ready_accept", req_ready_a, 1'b1);
        step();
        req_valid_a = hold;
        req_addr_a  = busy_addr;
        req_burst_a = ~burst;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check("a_addr_pins", addr_pins_a, addr[k*4 +: 4]);
            check("a_addr_start", addr_start_a, (k == 0));
            check("a_busy", busy_a, 1'b1);
        end
        step();
        check("a_wait_pins", addr_pins_a, 4'h0);
        check("a_wait_start", addr_start_a, 1'b0);
        for (int w = 0; w <= int'(burst); w++) begin
            for (int j = 0; j < 4; j++) begin
                step();
                data_pins_a = words[w][j*4 +: 4];
                if (j == 3) sb_a.push_back('{words[w], (w == int'(burst)), cyc + 1});
            end
        end
        step();
        data_pins_a = 4'h0;
        check("a_ready_end", req_ready_a, 1'b1);
        check("a_busy_end", busy_a, 1'b0);
        check("a_sb_drained", sb_a.size(), 0);
    endtask

    task automatic req_b(input logic [15:0] addr, input logic [1:0] burst,
                         input logic [3:0][7:0] words);
        req_valid_b = 1'b1;
        req_addr_b  = addr;
        req_burst_b = burst;
        check("b_ready_accept", req_ready_b, 1'b1);
        step();
        req_valid_b = 1'b0;
        req_addr_b  = ~addr;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            check("b_addr_pins", addr_pins_b, addr[k*2 +: 2]);
            check("b_addr_start", addr_start_b, (k == 0));
        end
        for (int w = 0; w <= int'(burst); w++) begin
            for (int j = 0; j < 4; j++) begin
                step();
                data_pins_b = words[w][j*2 +: 2];
                check("b_data_phase_pins", addr_pins_b, 2'b00);
                if (j == 3) sb_b.push_back('{{8'h00, words[w]}, (w == int'(burst)), cyc + 1});
            end
        end
        step();
        data_pins_b = 2'b00;
        check("b_ready_end", req_ready_b, 1'b1);
        check("b_busy_end", busy_b, 1'b0);
        check("b_sb_drained", sb_b.size(), 0);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid_a = 1'b0; req_addr_a = '0; req_burst_a = '0; data_pins_a = '0;
        req_valid_b = 1'b0; req_addr_b = '0; req_burst_b = '0; data_pins_b = '0;

        // Reset state
        #12;
        check("rst_addr_pins", addr_pins_a, 4'h0);
        check("rst_addr_start", addr_start_a, 1'b0);
        check("rst_rsp_valid", rsp_valid_a, 1'b0);
        check("rst_rsp_last", rsp_last_a, 1'b0);
        check("rst_rsp_data", rsp_data_a, 16'h0000);
        check("rst_busy", busy_a, 1'b0);
        step();
        #3 reset = 1'b0;
        step();
        check("rst_ready_after", req_ready_a, 1'b1);
        check("rst_ready_after_b", req_ready_b, 1'b1);

        // Single word
        req_a(16'hA5C3, 2'd0, {16'h0, 16'h0, 16'h0, 16'h4321}, 1'b0, 16'hFFFF);
        step();

        // Four-word burst
        req_a(16'h2468, 2'd3, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b0, 16'h0000);
        step();
        check("burst_busy_after", busy_a, 1'b0);

        // Back-to-back with req_valid held and req_addr changed while busy
        req_a(16'h0010, 2'd0, {16'h0, 16'h0, 16'h0, 16'hBEEF}, 1'b1, 16'h0020);
        req_a(16'h0020, 2'd1, {16'h0, 16'h0, 16'h9876, 16'hCAFE}, 1'b0, 16'hFFFF);
        step();

        // 2-pin, zero-latency build
        req_b(16'hB42D, 2'd1, {8'h00, 8'h00, 8'hC3, 8'h5A});
        step();

        // Asynchronous reset in the second word of a burst
        req_valid_a = 1'b1;
        req_addr_a  = 16'h1234;
        req_burst_a = 2'd1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 1) req_valid_a = 1'b0;
            if (c >= 6) data_pins_a = 4'(c - 5);
            if (c == 9) sb_a.push_back('{16'h4321, 1'b0, cyc + 1});
        end
        check("pre_rst_busy", busy_a, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_addr_pins", addr_pins_a, 4'h0);
        check("async_rst_addr_start", addr_start_a, 1'b0);
        check("async_rst_rsp_valid", rsp_valid_a, 1'b0);
        check("async_rst_rsp_last", rsp_last_a, 1'b0);
        check("async_rst_rsp_data", rsp_data_a, 16'h0000);
        check("async_rst_busy", busy_a, 1'b0);
        data_pins_a = 4'h0;
        step();
        step();
        #3 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("post_rst_busy", busy_a, 1'b0);
        end
        check("post_rst_ready", req_ready_a, 1'b1);
        req_a(16'hA5C3, 2'd0, {16'h0, 16'h0, 16'h0, 16'h4321}, 1'b0, 16'hFFFF);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
